alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_driver.sv | 147 ++++++++++++++
 tb/tb_alu_driver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, FSM states,
// response flag/error bit positions and the default ALU settle time.
package alu_pkg;

  localparam int unsigned SETTLE_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  // rsp_flags = {overflow, greater, is_eq, less, parity}
  localparam int unsigned FLAG_PARITY   = 0;
  localparam int unsigned FLAG_LESS     = 1;
  localparam int unsigned FLAG_IS_EQ    = 2;
  localparam int unsigned FLAG_GREATER  = 3;
  localparam int unsigned FLAG_OVERFLOW = 4;

  // rsp_err = {cmp_err, parity_err}
  localparam int unsigned ERR_PARITY = 0;
  localparam int unsigned ERR_CMP    = 1;

  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/alu_driver.sv
// Drives one command at a time onto an external ALU, waits for it to settle,
// captures result and flags with consistency checks, and returns a response.
module alu_driver
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_tag,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_oe,
  input  logic [7:0] alu_y,
  input  logic       alu_parity,
  input  logic       alu_overflow,
  input  logic       alu_greater,
  input  logic       alu_is_eq,
  input  logic       alu_less,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [3:0] rsp_tag,
  output logic [4:0] rsp_flags,
  output logic [1:0] rsp_err,
  output logic [15:0] cmd_count,
  output logic [7:0] err_count
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  alu_op_e     op_q, op_d;
  logic [3:0]  tag_q, tag_d;
  logic [7:0]  rsp_y_q, rsp_y_d;
  logic [4:0]  rsp_flags_q, rsp_flags_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [15:0] cmd_count_q, cmd_count_d;
  logic [7:0]  err_count_q, err_count_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    tag_d       = tag_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    cmd_count_d = cmd_count_q;
    err_count_d = err_count_q;
    cmd_ready   = 1'b0;
    alu_oe      = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = alu_op_e'(cmd_op);
          tag_d   = cmd_tag;
          cnt_d   = CNT_INIT;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        alu_oe = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_CAPTURE: begin
        alu_oe                     = 1'b1;
        rsp_y_d                    = alu_y;
        rsp_flags_d[FLAG_OVERFLOW] = alu_overflow;
        rsp_flags_d[FLAG_GREATER]  = alu_greater;
        rsp_flags_d[FLAG_IS_EQ]    = alu_is_eq;
        rsp_flags_d[FLAG_LESS]     = alu_less;
        rsp_flags_d[FLAG_PARITY]   = alu_parity;
        // Reported parity must match the parity of the reported result.
        rsp_err_d[ERR_PARITY]      = alu_parity ^ (^alu_y);
        rsp_err_d[ERR_CMP]         = ~is_one_hot3({alu_greater, alu_is_eq, alu_less});
        state_d                    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          cmd_count_d = cmd_count_q + 16'd1;
          if ((rsp_err_q != 2'b00) && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      tag_q       <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= '0;
      cmd_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      cmd_count_q <= cmd_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_tag   = tag_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign cmd_count = cmd_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: table of commands with expected
// responses, a response scoreboard queue, and directed multi-cycle sequences.
module tb_alu_driver;

  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_op;
  logic        alu_oe;
  logic [7:0]  alu_y;
  logic        alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_y;
  logic [3:0]  rsp_tag;
  logic [4:0]  rsp_flags;
  logic [1:0]  rsp_err;
  logic [15:0] cmd_count;
  logic [7:0]  err_count;

  logic par_flip, cmp_fault;

  always #5 clk = ~clk;

  alu_driver #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_oe(alu_oe),
    .alu_y(alu_y), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
    .alu_greater(alu_greater), .alu_is_eq(alu_is_eq), .alu_less(alu_less),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .cmd_count(cmd_count), .err_count(err_count)
  );

  // External ALU model with fault injection knobs
  logic [7:0] m_y;
  logic       m_ovf;
  always_comb begin
    m_y   = '0;
    m_ovf = 1'b0;
    case (alu_op)
      2'b00: begin
        m_y   = alu_a + alu_b;
        m_ovf = (alu_a[7] == alu_b[7]) && (m_y[7] != alu_a[7]);
      end
      2'b01: begin
        m_y   = alu_a - alu_b;
        m_ovf = (alu_a[7] != alu_b[7]) && (m_y[7] != alu_a[7]);
      end
      2'b10:   m_y = alu_a & alu_b;
      default: m_y = alu_a ^ alu_b;
    endcase
  end
  assign alu_y        = m_y;
  assign alu_overflow = m_ovf;
  assign alu_parity   = (^m_y) ^ par_flip;
  assign alu_greater  = cmp_fault | (alu_a > alu_b);
  assign alu_less     = cmp_fault | (alu_a < alu_b);
  assign alu_is_eq    = (alu_a == alu_b);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [3:0] tag;
    logic       pflip;
    logic       cfault;
    logic [7:0] y;
    logic [4:0] flags;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [15:0] exp_cmd_count;
  int unsigned exp_err_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_alu_oe"}, alu_oe, 0);
    check({tag, "_alu_abop"}, {alu_a, alu_b, alu_op}, 0);
    check({tag, "_rsp_fields"}, {rsp_y, rsp_flags, rsp_err, rsp_tag}, 0);
    check({tag, "_counts"}, {cmd_count, err_count}, 0);
  endtask

  // Issue one command, optionally backpressure the response for 'hold' cycles.
  task automatic run_cmd(input vec_t v, input int unsigned hold);
    int unsigned lat;
    vec_t e;
    logic [18:0] snap;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    par_flip  = v.pflip;
    cmp_fault = v.cfault;
    cmd_valid = 1'b1;
    cmd_a = v.a; cmd_b = v.b; cmd_op = v.op; cmd_tag = v.tag;
    @(negedge clk);
    cmd_valid = 1'b0;
    sb.push_back(v);
    check("alu_oe_drive", alu_oe, 1);
    check("alu_operands", {alu_a, alu_b, alu_op}, {v.a, v.b, v.op});
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, SETTLE + 2);
    snap = {rsp_y, rsp_flags, rsp_err, rsp_tag};
    for (int unsigned i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 8'hEE; cmd_b = 8'h11; cmd_op = 2'b11; cmd_tag = 4'hC;
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_stable", {rsp_y, rsp_flags, rsp_err, rsp_tag}, snap);
    end
    cmd_valid = 1'b0;
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("rsp_y", rsp_y, e.y);
      check("rsp_flags", rsp_flags, e.flags);
      check("rsp_err", rsp_err, e.err);
      check("rsp_tag", rsp_tag, e.tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      exp_cmd_count = exp_cmd_count + 16'd1;
      if (e.err != 2'b00 && exp_err_count < 255) exp_err_count++;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("cmd_count", cmd_count, exp_cmd_count);
    check("err_count", err_count, exp_err_count);
    check("alu_hold", {alu_a, alu_b, alu_op}, {v.a, v.b, v.op});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int unsigned seen;
    //             a      b      op     tag   pf    cf    y      flags     err
    vecs[0] = '{8'h12, 8'h34, 2'b00, 4'h5, 1'b0, 1'b0, 8'h46, 5'b00011, 2'b00};
    vecs[1] = '{8'h80, 8'h01, 2'b01, 4'h3, 1'b0, 1'b0, 8'h7F, 5'b11001, 2'b00};
    vecs[2] = '{8'hF0, 8'hF0, 2'b10, 4'hA, 1'b0, 1'b0, 8'hF0, 5'b00100, 2'b00};
    vecs[3] = '{8'h5A, 8'hFF, 2'b11, 4'hF, 1'b0, 1'b0, 8'hA5, 5'b00010, 2'b00};
    vecs[4] = '{8'h7F, 8'h01, 2'b00, 4'h0, 1'b0, 1'b0, 8'h80, 5'b11001, 2'b00};
    vecs[5] = '{8'h12, 8'h34, 2'b00, 4'h5, 1'b1, 1'b0, 8'h46, 5'b00010, 2'b01};
    vecs[6] = '{8'h12, 8'h34, 2'b00, 4'h6, 1'b0, 1'b1, 8'h46, 5'b01011, 2'b10};
    vecs[7] = '{8'h00, 8'h00, 2'b11, 4'h9, 1'b1, 1'b1, 8'h00, 5'b01111, 2'b11};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    par_flip = 1'b0; cmp_fault = 1'b0;
    exp_cmd_count = '0; exp_err_count = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int unsigned i = 0; i < 8; i++) run_cmd(vecs[i], 0);

    // Backpressure: response held for 5 cycles while a new command is offered
    run_cmd(vecs[1], 5);

    // Reset one cycle after accept: command must vanish without a response
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 2'b00; cmd_tag = 4'h7;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_drive_oe", alu_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    seen = 0;
    rsp_ready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    check("mid_rst_no_rsp", seen, 0);
    check("mid_rst_counts", {cmd_count, err_count}, 0);
    exp_cmd_count = '0; exp_err_count = 0;
    run_cmd(vecs[0], 0);

    // Error counter saturation
    for (int unsigned i = 0; i < 300; i++) run_cmd(vecs[5], 0);
    check("err_sat", err_count, 8'hFF);

    // Command counter wrap from a preloaded 0xFFFF
    @(negedge clk);
    force dut.cmd_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.cmd_count_q;
    @(negedge clk);
    check("preload", cmd_count, 16'hFFFF);
    exp_cmd_count = 16'hFFFF;
    rv = vecs[2];
    run_cmd(rv, 0);
    check("cmd_wrap", cmd_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
